// File: rtl/apb_arbiter.sv
// APB master shared by NUM_REQ local requesters.
//
// Requesters raise req_valid with a payload (write, addr, wdata) and hold it until their
// req_done pulse. A round-robin arbiter picks one requester per IDLE cycle, then a standard
// SETUP/ACCESS transfer runs on the APB bus. A bus timer aborts a transfer that never sees
// pready within BUS_TIMER_EXPIRATION ACCESS cycles.
//
// Ports:
//   clk, reset_n          clock (posedge) and asynchronous active-low reset
//   req_valid/write       per-requester request and direction
//   req_addr/wdata        packed payloads, requester i at [i*W +: W]
//   req_done              one-hot single-cycle completion pulse
//   req_rdata, req_err    completion data/status, valid while req_done is high, held after
//   psel ... pwdata       APB master outputs (all registered)
//   prdata, pready,       APB slave responses
//   pslverr
module apb_arbiter #(
    parameter int unsigned NUM_REQ              = 4,
    parameter int unsigned ADDR_WIDTH           = 32,
    parameter int unsigned DATA_WIDTH           = 32,
    parameter int unsigned BUS_TIMER_EXPIRATION = 100
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_done,
    output logic [DATA_WIDTH-1:0]            req_rdata,
    output logic                             req_err,
    output logic                             psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    input  logic [DATA_WIDTH-1:0]            prdata,
    input  logic                             pready,
    input  logic                             pslverr
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = $clog2(BUS_TIMER_EXPIRATION + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                  state_q, state_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]      req_done_q, req_done_d;
    logic [DATA_WIDTH-1:0]   req_rdata_q, req_rdata_d;
    logic                    req_err_q, req_err_d;

    logic                    grant_found;
    logic [GW-1:0]           grant_idx;
    logic [31:0]             scan_idx;

    // Round-robin search: first set request strictly after last_grant, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (32'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[scan_idx[GW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        req_done_d   = '0;
        req_rdata_d  = req_rdata_q;
        req_err_d    = req_err_q;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    last_grant_d = grant_idx;
                    pwrite_d     = req_write[grant_idx];
                    paddr_d      = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_d     = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                    state_d      = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                if (pready || (timer_q == TW'(BUS_TIMER_EXPIRATION - 1))) begin
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    pwrite_d   = 1'b0;
                    paddr_d    = '0;
                    pwdata_d   = '0;
                    req_done_d = NUM_REQ'(1) << last_grant_q;
                    if (pready) begin
                        req_rdata_d = pwrite_q ? '0 : prdata;
                        req_err_d   = pslverr;
                    end else begin
                        // Timeout abort: error regardless of slave state.
                        req_rdata_d = '0;
                        req_err_d   = 1'b1;
                    end
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= GW'(NUM_REQ - 1);
            timer_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            req_done_q   <= '0;
            req_rdata_q  <= '0;
            req_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            req_done_q   <= req_done_d;
            req_rdata_q  <= req_rdata_d;
            req_err_q    <= req_err_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign req_done  = req_done_q;
    assign req_rdata = req_rdata_q;
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter (NUM_REQ=4, 32-bit bus, bus timer of 5 cycles).
module tb_apb_arbiter;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    req_valid;
    logic [3:0]    req_write;
    logic [127:0]  req_addr;
    logic [127:0]  req_wdata;
    logic [3:0]    req_done;
    logic [31:0]   req_rdata;
    logic          req_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [31:0]   paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;

    int total = 0;
    int bad   = 0;

    apb_arbiter #(
        .NUM_REQ              (4),
        .ADDR_WIDTH           (32),
        .DATA_WIDTH           (32),
        .BUS_TIMER_EXPIRATION (5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int cnt;
    int guard;
    int idx;

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #12;
        chk("rst_psel", 64'(psel), 0);
        chk("rst_penable", 64'(penable), 0);
        chk("rst_paddr", 64'(paddr), 0);
        chk("rst_done", 64'(req_done), 0);
        chk("rst_rdata", 64'(req_rdata), 0);
        chk("rst_err", 64'(req_err), 0);
        reset_n = 1'b1;
        tick();

        // 1: single zero-wait write from requester 1.
        req_valid[1]       = 1'b1;
        req_write[1]       = 1'b1;
        req_addr[32 +: 32] = 32'h0000_1000;
        req_wdata[32 +: 32] = 32'hDEAD_BEEF;
        pready             = 1'b1;
        tick();
        chk("t1_psel", 64'(psel), 1);
        chk("t1_setup_pen", 64'(penable), 0);
        tick();
        chk("t1_pen", 64'(penable), 1);
        chk("t1_pwrite", 64'(pwrite), 1);
        chk("t1_paddr", 64'(paddr), 64'h1000);
        chk("t1_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
        tick();
        chk("t1_done", 64'(req_done), 64'b0010);
        chk("t1_err", 64'(req_err), 0);
        chk("t1_rdata", 64'(req_rdata), 0);
        chk("t1_psel_off", 64'(psel), 0);
        req_valid[1] = 1'b0;

        // 2: read from requester 2 with three wait states.
        req_valid[2]       = 1'b1;
        req_write[2]       = 1'b0;
        req_addr[64 +: 32] = 32'h20;
        prdata             = 32'h1234_5678;
        pready             = 1'b0;
        tick();
        chk("t2_paddr", 64'(paddr), 64'h20);
        chk("t2_pwrite", 64'(pwrite), 0);
        tick();
        cnt   = 0;
        guard = 0;
        while (req_done == 4'b0 && guard < 20) begin
            if (penable) cnt++;
            pready = (cnt >= 4);
            guard++;
            tick();
        end
        chk("t2_pen_cycles", 64'(cnt), 4);
        chk("t2_done", 64'(req_done), 64'b0100);
        chk("t2_rdata", 64'(req_rdata), 64'h1234_5678);
        chk("t2_err", 64'(req_err), 0);
        req_valid[2] = 1'b0;
        tick();
        chk("t2_single_pulse", 64'(req_done), 0);
        chk("t2_rdata_hold", 64'(req_rdata), 64'h1234_5678);

        // 3: contention from reset; requester 0 keeps requesting.
        reset_n = 1'b0;
        #3;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32]  = 32'h100 + 32'(i * 16);
            req_wdata[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        end
        req_write = 4'b1111;
        req_valid = 4'b1111;
        pready    = 1'b1;
        reset_n   = 1'b1;
        tick();
        for (int n = 0; n < 5; n++) begin
            idx = order[n];
            chk("t3_psel", 64'(psel), 1);
            chk("t3_grant_addr", 64'(paddr), 64'h100 + 64'(idx * 16));
            tick();
            chk("t3_pen", 64'(penable), 1);
            tick();
            chk("t3_done", 64'(req_done), 64'(1) << idx);
            chk("t3_gap", 64'(psel), 0);
            if (idx != 0) req_valid[idx] = 1'b0;
            if (n == 4) req_valid[0] = 1'b0;
            tick();
        end

        // 4: timeout on requester 3 read, then a normal transfer.
        req_valid[3]       = 1'b1;
        req_write[3]       = 1'b0;
        req_addr[96 +: 32] = 32'h30;
        prdata             = 32'hFFFF_0000;
        pready             = 1'b0;
        tick();
        chk("t4_paddr", 64'(paddr), 64'h30);
        tick();
        cnt   = 0;
        guard = 0;
        while (req_done == 4'b0 && guard < 20) begin
            if (penable) cnt++;
            guard++;
            tick();
        end
        chk("t4_pen_cycles", 64'(cnt), 5);
        chk("t4_done", 64'(req_done), 64'b1000);
        chk("t4_err", 64'(req_err), 1);
        chk("t4_rdata", 64'(req_rdata), 0);
        req_valid[3]        = 1'b0;
        req_valid[1]        = 1'b1;
        req_write[1]        = 1'b1;
        req_addr[32 +: 32]  = 32'h44;
        req_wdata[32 +: 32] = 32'hA5A5_A5A5;
        pready              = 1'b1;
        tick();
        chk("t4b_paddr", 64'(paddr), 64'h44);
        tick();
        tick();
        chk("t4b_done", 64'(req_done), 64'b0010);
        chk("t4b_err", 64'(req_err), 0);
        req_valid[1] = 1'b0;

        // 5: slave error on a write from requester 2.
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        pslverr      = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_done", 64'(req_done), 64'b0100);
        chk("t5_err", 64'(req_err), 1);
        req_valid[2] = 1'b0;
        tick();
        chk("t5_idle_psel", 64'(psel), 0);
        chk("t5_idle_pen", 64'(penable), 0);
        chk("t5_idle_done", 64'(req_done), 0);
        pslverr = 1'b0;

        // 6: reset pulsed during ACCESS.
        req_valid[3] = 1'b1;
        pready       = 1'b0;
        tick();
        tick();
        chk("t6_pen_before", 64'(penable), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_psel", 64'(psel), 0);
        chk("t6_pen", 64'(penable), 0);
        chk("t6_paddr", 64'(paddr), 0);
        chk("t6_done", 64'(req_done), 0);
        req_valid = 4'b1111;
        pready    = 1'b1;
        tick();
        chk("t6_no_done", 64'(req_done), 0);
        reset_n = 1'b1;
        tick();
        chk("t6_regrant_psel", 64'(psel), 1);
        chk("t6_regrant_addr", 64'(paddr), 64'h100);
        req_valid = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Synthesizable APB master that shares one APB bus among NUM_REQ local requesters. Each requester has a simple valid/done interface.
- Round-robin arbitration selects one requester, then runs a standard APB SETUP/ACCESS transfer.
- A bus timer aborts a transfer if pready never arrives.
- Sits between register-access clients (config engines, debug mailboxes) and the APB register fabric.

Parameters:
NUM_REQ, 4, number of requesters; range 2..8
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
BUS_TIMER_EXPIRATION, 100, ACCESS cycles without pready before abort; must be >= 1

Ports:
clk  input  1  clock; all logic on posedge
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request; hold until matching req_done
req_write  input  NUM_REQ  1 = write, 0 = read
req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, same packing
req_done  output  NUM_REQ  one-hot single-cycle completion pulse
req_rdata  output  DATA_WIDTH  read data; valid in the req_done cycle
req_err  output  1  1 = pslverr or timeout; valid in the req_done cycle
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_WIDTH  APB address
pwdata  output  DATA_WIDTH  APB write data
prdata  input  DATA_WIDTH  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM = IDLE; bus timer = 0; round-robin pointer last_grant = NUM_REQ-1, so requester 0 has priority first.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid bit is set, grant the first set bit searching upward from last_grant+1, with wrap-around modulo NUM_REQ.
  - On grant: last_grant <= g; latch that requester's addr, wdata and write into paddr, pwdata and pwrite.
  - On grant: psel <= 1, penable <= 0, go to SETUP.
  - If no req_valid bit is set, stay in IDLE.
- SETUP:
  - Always lasts exactly one cycle: penable <= 1, go to ACCESS.
  - pready in SETUP is ignored.
- ACCESS, pready = 1: complete the transfer.
  - psel, penable, pwrite, paddr and pwdata <= 0.
  - req_done[g] <= 1 for exactly one cycle.
  - req_rdata <= prdata for reads, 0 for writes.
  - req_err <= pslverr.
  - Timer <= 0; go to IDLE.
- ACCESS, pready = 0:
  - If timer == BUS_TIMER_EXPIRATION-1: complete as above, but with req_err = 1 and req_rdata = 0, regardless of pslverr.
  - Otherwise timer increments.
  - Net effect: an abort happens after exactly BUS_TIMER_EXPIRATION ACCESS cycles without pready.
- Timer width: $clog2(BUS_TIMER_EXPIRATION+1).
- Bus gap: psel is low for at least one cycle between transfers. IDLE is always entered after completion, and a new grant can happen in that IDLE cycle.
- Minimum latency: req_valid sampled in cycle 0 → psel in cycle 1 → penable in cycle 2 → pready sampled in cycle 2 → req_done in cycle 3.
- Request payload and withdrawal:
  - The payload is captured only at grant; changes after grant are ignored.
  - A requester may drop req_valid before it is granted (withdraw).
  - Dropping req_valid after grant does not cancel the transfer; req_done still pulses.
- req_rdata and req_err hold their values until the next completion. Consumers sample them only when req_done is high.
- Reset asserted mid-transfer: everything clears immediately (asynchronously) and no req_done is issued.
- Simultaneous requests: exactly one grant per IDLE cycle; there is never more than one outstanding transfer.

Test Plan:
1. Single write: req_valid[1] with addr 0x1000 and wdata 0xDEADBEEF; slave pready=1 with no wait states → psel in cycle 1, penable in cycle 2 with pwrite=1, paddr=0x1000, pwdata=0xDEADBEEF; req_done=4'b0010 in cycle 3; req_err=0.
2. Read with waits: req 2 reads 0x20; slave inserts 3 wait states, then returns prdata=0x12345678 → penable high for 4 cycles; req_done[2] pulses once with req_rdata=0x12345678 and req_err=0.
3. Contention: all four req_valid held high from reset, each deasserted after its done → grant order 0,1,2,3; req_valid[0] re-asserted after its done → grant order continues 0 after 3; psel low for one cycle between each transfer.
4. Timeout: BUS_TIMER_EXPIRATION=5 and pready held 0 → penable high for exactly 5 cycles; then req_done pulses with req_err=1 and req_rdata=0; the next request proceeds normally.
5. Slave error: write with pslverr=1 and pready=1 → req_err=1 in the done cycle; the bus returns to idle.
6. Reset mid-ACCESS: reset_n pulsed low while penable=1 → psel, penable, paddr and req_done are 0 immediately; no done pulse; after release, requester 0 wins first.
